aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
Sequencer for the AES-128 key-expansion datapath (aes_key_gen). On a start request it loads the cipher key, then steps the expander through rounds 1..NR, issuing the round constant and round strobes for each round. It hands each round key to the round datapath with a valid/ready handshake. It also arbitrates the single shared 32-bit SubWord S-box between the key expander and the round datapath.

Parameters:
NR, 10, number of expansion rounds (AES-128); legal 1..10
RCON_INIT, 8'h01, rcon for round 1

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start_i  in  1  start expansion; sampled only in IDLE
abort_i  in  1  abandon current expansion
busy_o  out  1  high in any state except IDLE
done_o  out  1  1-cycle pulse after round NR key accepted
kg_en_o  out  1  expander enable
kg_gen_key_o  out  1  load key_i into expander (LOAD cycle)
kg_next_rnd_o  out  1  expander round-update strobe (UPD cycle)
kg_rcon_o  out  8  rcon to expander (r_con_i)
sbox_sel_o  out  1  S-box input mux: 1=key expander, 0=datapath
dp_sbox_req_i  in  1  datapath requests S-box this cycle
dp_sbox_gnt_o  out  1  datapath S-box grant
rk_valid_o  out  1  expander key_o holds round key rk_idx_o
rk_idx_o  out  4  round index of presented key, 0..NR
rk_ready_i  in  1  consumer accepts round key

Behaviour:
- Reset (async, nrst=0): state=IDLE, rnd=0, rcon=RCON_INIT; all outputs 0.
- State machine: IDLE, LOAD, HOLD, SUB, UPD.
- IDLE: start_i=1 -> LOAD.
- LOAD (1 cycle): kg_en=1, kg_gen_key=1. Next state HOLD, rnd=0.
- HOLD: rk_valid=1, rk_idx=rnd. Holds until rk_ready_i=1; acceptance is the same cycle valid&ready.
  - Accepted with rnd==NR -> IDLE, done_o=1 on the following cycle (first IDLE cycle).
  - Accepted otherwise -> SUB.
- SUB (1 cycle): kg_en=1, sbox_sel=1, kg_rcon=rcon.
- UPD (1 cycle): kg_en=1, kg_next_rnd=1, kg_rcon=rcon. On exit: rnd+=1; rcon=xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). Next state HOLD.
- Rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. Reset to RCON_INIT on every start.
- kg_rcon_o is 0 outside SUB/UPD. kg_en_o is 0 in IDLE and HOLD, so the expander holds key_o stable while presented.
- S-box arbitration:
  - Key expander has absolute priority in SUB.
  - dp_sbox_gnt_o = dp_sbox_req_i & ~(state==SUB), combinational.
  - sbox_sel_o = (state==SUB).
  - A denied datapath must hold its request; the grant is never lost for more than 1 cycle per round.
- Latency with rk_ready_i tied 1:
  - round 0 valid 2 cycles after the start cycle;
  - every later round 3 cycles after the previous one;
  - done 3*NR+3 cycles after start.
- abort_i=1 in any state -> IDLE next cycle; rnd/rcon reset; no done pulse; rk_valid drops. Abort has priority over every other transition, including start in IDLE and acceptance in HOLD.
- start_i while busy: ignored, no effect.
- start_i in the same cycle done_o is high (first IDLE cycle): accepted normally.
- nrst asserted mid-expansion: immediate return to reset values. The expander's key register is not considered valid afterwards.
- rk_idx_o width is 4 bits; rnd never exceeds NR.

Test Plan:
1. Reset with nrst=0 mid-SUB -> all outputs 0 immediately (asynchronous), state IDLE; after release, no activity until start_i.
2. start_i=1 at cycle 0, rk_ready_i=1 -> kg_gen_key=1 at cycle 1; rk_valid with idx 0,1,...,10 at cycles 2,5,...,32; done_o at cycle 33; kg_rcon in SUB cycles = 01,02,04,08,10,20,40,80,1b,36.
3. rk_ready_i=0 for 5 cycles at rnd=3 -> rk_valid/rk_idx=3 held; kg_en=0 throughout; SUB follows the cycle after ready=1; rcon=08.
4. dp_sbox_req_i=1 constantly during expansion -> gnt=0 exactly in the 10 SUB cycles, 1 elsewhere; sbox_sel=1 only in SUB.
5. abort_i=1 during UPD of round 5 -> IDLE next cycle, busy=0, no done; a fresh start yields rcon 01 for round 1.
6. start_i held high during expansion and at done -> second start ignored while busy; accepted on the done_o cycle, LOAD in the next cycle.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 key expander: loads the key, steps rounds 1..NR,
// presents each round key with valid/ready, and arbitrates the shared S-box.
module aes_key_sched_ctrl #(
    parameter int          NR        = 10,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       kg_en_o,
    output logic       kg_gen_key_o,
    output logic       kg_next_rnd_o,
    output logic [7:0] kg_rcon_o,
    output logic       sbox_sel_o,
    input  logic       dp_sbox_req_i,
    output logic       dp_sbox_gnt_o,
    output logic       rk_valid_o,
    output logic [3:0] rk_idx_o,
    input  logic       rk_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_SUB,
        S_UPD
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_rnd;
    logic [7:0] r_rcon;
    logic       r_done;
    logic       w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign w_accept = (r_state == S_HOLD) && rk_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rnd  <= 4'd0;
            r_rcon <= RCON_INIT;
            r_done <= 1'b0;
        end else begin
            r_done <= !abort_i && w_accept && (r_rnd == LAST_RND);
            if (abort_i) begin
                r_rnd  <= 4'd0;
                r_rcon <= RCON_INIT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_rnd  <= 4'd0;
                            r_rcon <= RCON_INIT;
                        end
                    end
                    S_UPD: begin
                        r_rnd  <= r_rnd + 4'd1;
                        r_rcon <= xtime(r_rcon);
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        if (abort_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start_i) w_next = S_LOAD;
                S_LOAD:  w_next = S_HOLD;
                S_HOLD:  if (rk_ready_i) w_next = (r_rnd == LAST_RND) ? S_IDLE : S_SUB;
                S_SUB:   w_next = S_UPD;
                S_UPD:   w_next = S_HOLD;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o        = (r_state != S_IDLE);
        done_o        = r_done;
        kg_en_o       = 1'b0;
        kg_gen_key_o  = 1'b0;
        kg_next_rnd_o = 1'b0;
        kg_rcon_o     = 8'h00;
        sbox_sel_o    = 1'b0;
        rk_valid_o    = 1'b0;
        rk_idx_o      = 4'd0;
        case (r_state)
            S_LOAD: begin
                kg_en_o      = 1'b1;
                kg_gen_key_o = 1'b1;
            end
            S_HOLD: begin
                rk_valid_o = 1'b1;
                rk_idx_o   = r_rnd;
            end
            S_SUB: begin
                kg_en_o    = 1'b1;
                sbox_sel_o = 1'b1;
                kg_rcon_o  = r_rcon;
            end
            S_UPD: begin
                kg_en_o       = 1'b1;
                kg_next_rnd_o = 1'b1;
                kg_rcon_o     = r_rcon;
            end
            default: ;
        endcase
        // The key expander owns the S-box outright during SUB.
        dp_sbox_gnt_o = dp_sbox_req_i && (r_state != S_SUB);
    end

endmodule
